bcd_to_bin: RTL

- Sequential 4-digit BCD-to-binary converter; the inverse of the team's binary-to-BCD display path.
- Takes thousands/hundreds/tens/ones digits, for example from keypad or preset entry of a timer value, and returns the binary count.
- Uses reverse double-dabble, one shift per clock.
- Start/busy/done handshake; the result is held until the next conversion.

---
 rtl/bcd_to_bin.sv | 99 +++++++++
 1 files changed

// File: rtl/bcd_to_bin.sv
// Sequential 4-digit BCD-to-binary converter (reverse double-dabble, one shift per clock).
// Optional invalid-digit rejection is enabled by defining BCD_RANGE_CHECK_EN.
//
// state  | meaning
// IDLE   | waiting for start; timer and err hold
// CONV   | one shift/adjust step per clock, 14 steps
// DONE   | one-cycle done pulse, then back to IDLE
module bcd_to_bin #(
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       digit1,
    input  logic [3:0]       digit2,
    input  logic [3:0]       digit3,
    input  logic [3:0]       digit4,
    output logic [OUT_W-1:0] timer,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] LAST_STEP = 4'd13;

    logic [1:0]  state;
    logic [3:0]  count;
    logic [29:0] work;
    logic [29:0] shifted;
    logic [29:0] step_w;

    function automatic logic [3:0] adjust(input logic [3:0] nib);
        return (nib >= 4'd8) ? (nib - 4'd3) : nib;
    endfunction

    // Upper four nibbles hold the BCD digits being halved; low 14 bits collect the binary result.
    assign shifted = {1'b0, work[29:1]};
    assign step_w  = {adjust(shifted[29:26]), adjust(shifted[25:22]),
                      adjust(shifted[21:18]), adjust(shifted[17:14]), shifted[13:0]};

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            count <= 4'd0;
            work  <= 30'd0;
            timer <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
`ifdef BCD_RANGE_CHECK_EN
                        if ((digit1 > 4'd9) || (digit2 > 4'd9) ||
                            (digit3 > 4'd9) || (digit4 > 4'd9)) begin
                            err   <= 1'b1;
                            timer <= '0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            work  <= {digit4, digit3, digit2, digit1, 14'd0};
                            count <= 4'd0;
                            state <= S_CONV;
                        end
`else
                        work  <= {digit4, digit3, digit2, digit1, 14'd0};
                        count <= 4'd0;
                        state <= S_CONV;
`endif
                    end
                end
                S_CONV: begin
                    work  <= step_w;
                    count <= count + 4'd1;
                    if (count == LAST_STEP) begin
                        timer <= OUT_W'(step_w[13:0]);
                        done  <= 1'b1;
                        err   <= 1'b0;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
